wb_stage: RTL and testbench

- MEM/WB writeback stage feeding the register file's write port (dataW / rsW / RegWEn).
- Accepts one retiring instruction per handshake from the memory stage.
- Waits for the data-memory load response when needed, formats load data, and picks the writeback source.
- Emits exactly one registered write pulse per retired instruction, plus a retired-instruction counter.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/load_align.sv | 27 ++
 rtl/wb_stage.sv | 147 ++++++++++++++
 tb/tb_wb_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions: writeback source select, load funct3 codes
// and the writeback-stage state encoding.
package rv_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wbsel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_LOAD = 2'b01,
        DRAIN     = 2'b10
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts and extends a byte, halfword or word from a 32-bit load response.
// Purely combinational so the LSU can share it.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = word[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB writeback stage: waits for load data, selects the writeback source and
// issues one registered register-file write pulse per retired instruction.
module wb_stage
    import rv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             flush_i,
    input  logic [31:0]      alu_i,
    input  logic [31:0]      pc4_i,
    input  logic [4:0]       rd_i,
    input  logic             regwen_i,
    input  logic [1:0]       wbsel_i,
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       addr_lo_i,
    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic [31:0]      dataW_o,
    output logic [4:0]       rsW_o,
    output logic             RegWEn_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] retired_o
);

    wb_state_e   state_q, state_d;

    logic [4:0]  ld_rd;
    logic        ld_regwen;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_data;

    logic        hold_valid;
    logic [31:0] hold_data;
    logic [4:0]  hold_rd;
    logic        hold_regwen;

    logic        accept;
    logic        in_is_load;
    logic [31:0] in_data;
    logic        load_done;
    logic        hold_load;

    logic        wr_valid;
    logic [31:0] wr_data;
    logic [4:0]  wr_rd;
    logic        wr_regwen;

    load_align u_load_align (
        .word    (dmem_rdata_i),
        .addr_lo (ld_addr_lo),
        .funct3  (ld_funct3),
        .result  (ld_data)
    );

    assign ready_o    = (state_q == IDLE) ||
                        (state_q == WAIT_LOAD && dmem_rvalid_i && !flush_i);
    assign busy_o     = (state_q != IDLE);
    assign accept     = valid_i && ready_o && !flush_i;
    assign in_is_load = (wbsel_i == WB_MEM);
    assign in_data    = (wbsel_i == WB_PC4) ? pc4_i : alu_i;
    assign load_done  = (state_q == WAIT_LOAD) && dmem_rvalid_i && !flush_i;

    // A non-load that arrives while another write owns the output register
    // is parked in the hold slot and written on the following edge.
    assign hold_load  = accept && !in_is_load && (load_done || hold_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && in_is_load) state_d = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                if (flush_i)            state_d = dmem_rvalid_i ? IDLE : DRAIN;
                else if (dmem_rvalid_i) state_d = (accept && in_is_load) ? WAIT_LOAD : IDLE;
            end
            DRAIN: begin
                if (dmem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_valid  = 1'b0;
        wr_data   = in_data;
        wr_rd     = rd_i;
        wr_regwen = regwen_i;
        if (load_done) begin
            wr_valid  = 1'b1;
            wr_data   = ld_data;
            wr_rd     = ld_rd;
            wr_regwen = ld_regwen;
        end else if (hold_valid) begin
            wr_valid  = 1'b1;
            wr_data   = hold_data;
            wr_rd     = hold_rd;
            wr_regwen = hold_regwen;
        end else if (accept && !in_is_load) begin
            wr_valid  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ld_rd       <= '0;
            ld_regwen   <= 1'b0;
            ld_funct3   <= '0;
            ld_addr_lo  <= '0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            hold_rd     <= '0;
            hold_regwen <= 1'b0;
            dataW_o     <= '0;
            rsW_o       <= '0;
            RegWEn_o    <= 1'b0;
            retired_o   <= '0;
        end else begin
            state_q <= state_d;
            if (accept && in_is_load) begin
                ld_rd      <= rd_i;
                ld_regwen  <= regwen_i;
                ld_funct3  <= funct3_i;
                ld_addr_lo <= addr_lo_i;
            end
            hold_valid <= hold_load;
            if (hold_load) begin
                hold_data   <= in_data;
                hold_rd     <= rd_i;
                hold_regwen <= regwen_i;
            end
            RegWEn_o <= wr_valid && wr_regwen && (wr_rd != 5'd0);
            if (wr_valid) begin
                dataW_o   <= wr_data;
                rsW_o     <= wr_rd;
                retired_o <= retired_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by a randomized
// run scored against an in-order retirement model.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [31:0] alu_i;
    logic [31:0] pc4_i;
    logic [4:0]  rd_i;
    logic        regwen_i;
    logic [1:0]  wbsel_i;
    logic [2:0]  funct3_i;
    logic [1:0]  addr_lo_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    logic        ready_o, RegWEn_o, busy_o;
    logic [31:0] dataW_o;
    logic [4:0]  rsW_o;
    logic [31:0] retired_o;

    logic        ready4, regwen4, busy4;
    logic [31:0] dataw4;
    logic [4:0]  rsw4;
    logic [3:0]  retired4;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;

    always #5 clk_i = ~clk_i;

    wb_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .alu_i(alu_i), .pc4_i(pc4_i), .rd_i(rd_i),
        .regwen_i(regwen_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i),
        .addr_lo_i(addr_lo_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .dataW_o(dataW_o), .rsW_o(rsW_o),
        .RegWEn_o(RegWEn_o), .busy_o(busy_o), .retired_o(retired_o)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready4),
        .flush_i(flush_i), .alu_i(alu_i), .pc4_i(pc4_i), .rd_i(rd_i),
        .regwen_i(regwen_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i),
        .addr_lo_i(addr_lo_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .dataW_o(dataw4), .rsW_o(rsw4),
        .RegWEn_o(regwen4), .busy_o(busy4), .retired_o(retired4)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] wbsel, input logic [2:0] f3, input logic [4:0] rd,
                             input logic wen, input logic [31:0] alu, input logic [31:0] pc4,
                             input logic [1:0] alo);
        wbsel_i = wbsel; funct3_i = f3; rd_i = rd; regwen_i = wen;
        alu_i = alu; pc4_i = pc4; addr_lo_i = alo;
    endtask

    // Spec-level load formatting using shifts and masks.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f);
        logic [31:0] b, h;
        b = (w >> (32'(a) * 8)) & 32'hFF;
        h = (w >> (32'(a[1]) * 16)) & 32'hFFFF;
        case (f)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        set_instr(2'b00, 3'b010, 5'd0, 1'b0, '0, '0, 2'b00);
        tick(); tick();
        rst_i = 1'b0;
        checks++;
        if (RegWEn_o !== 1'b0 || dataW_o !== 32'd0 || rsW_o !== 5'd0 || retired_o !== 32'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: RegWEn=%b dataW=%h rsW=%0d retired=%0d busy=%b, required all 0",
                     RegWEn_o, dataW_o, rsW_o, retired_o, busy_o);
        end
        set_instr(2'b01, 3'b010, 5'd5, 1'b1, 32'h100, '0, 2'b00);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wait_load: busy=%b ready=%b, required busy=1 ready=0", busy_o, ready_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid_i = 1'b0;
        checks++;
        if (RegWEn_o !== 1'b0 || busy_o !== 1'b0 || retired_o !== 32'd0 || dataW_o !== 32'd0 || rsW_o !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_load: RegWEn=%b busy=%b retired=%0d dataW=%h rsW=%0d, required all 0",
                     RegWEn_o, busy_o, retired_o, dataW_o, rsW_o);
        end
        exp_ret = 0;
    endtask

    task automatic test_alu();
        set_instr(2'b00, 3'b000, 5'd3, 1'b1, 32'h0000_1234, 32'h8, 2'b00);
        valid_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_ready: ready=%b, required 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        exp_ret++;
        checks++;
        if (RegWEn_o !== 1'b1 || rsW_o !== 5'd3 || dataW_o !== 32'h0000_1234 || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL alu_write: RegWEn=%b rsW=%0d dataW=%h retired=%0d, required 1/3/00001234/%0d",
                     RegWEn_o, rsW_o, dataW_o, retired_o, exp_ret);
        end
        tick();
        checks++;
        if (RegWEn_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_pulse_width: RegWEn=%b, required 0", RegWEn_o);
        end
    endtask

    task automatic test_lb();
        set_instr(2'b01, 3'b000, 5'd7, 1'b1, 32'h202, '0, 2'b10);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ready_o !== 1'b0 || RegWEn_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL lb_waiting: ready=%b RegWEn=%b busy=%b, required 0/0/1", ready_o, RegWEn_o, busy_o);
            end
            if (i == 0) tick();
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0080_FF11;
        set_instr(2'b10, 3'b000, 5'd1, 1'b1, 32'h0, 32'h104, 2'b00);
        valid_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lb_ready_on_rvalid: ready=%b, required 1", ready_o);
        end
        tick();
        dmem_rvalid_i = 1'b0; valid_i = 1'b0;
        exp_ret++;
        checks++;
        if (RegWEn_o !== 1'b1 || rsW_o !== 5'd7 || dataW_o !== 32'hFFFF_FF80 || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL lb_write: RegWEn=%b rsW=%0d dataW=%h retired=%0d, required 1/7/ffffff80/%0d",
                     RegWEn_o, rsW_o, dataW_o, retired_o, exp_ret);
        end
        tick();
        exp_ret++;
        checks++;
        if (RegWEn_o !== 1'b1 || rsW_o !== 5'd1 || dataW_o !== 32'h0000_0104 || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL jal_after_load: RegWEn=%b rsW=%0d dataW=%h retired=%0d, required 1/1/00000104/%0d",
                     RegWEn_o, rsW_o, dataW_o, retired_o, exp_ret);
        end
        tick();
        checks++;
        if (RegWEn_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL jal_pulse_width: RegWEn=%b busy=%b, required 0/0", RegWEn_o, busy_o);
        end
    endtask

    task automatic test_lhu();
        set_instr(2'b01, 3'b101, 5'd2, 1'b1, 32'h402, '0, 2'b10);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
        tick();
        dmem_rvalid_i = 1'b0;
        exp_ret++;
        checks++;
        if (RegWEn_o !== 1'b1 || rsW_o !== 5'd2 || dataW_o !== 32'h0000_BEEF || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL lhu_write: RegWEn=%b rsW=%0d dataW=%h retired=%0d, required 1/2/0000beef/%0d",
                     RegWEn_o, rsW_o, dataW_o, retired_o, exp_ret);
        end
        tick();
    endtask

    task automatic test_flush();
        set_instr(2'b01, 3'b010, 5'd9, 1'b1, 32'h500, '0, 2'b00);
        valid_i = 1'b1;
        tick();
        set_instr(2'b00, 3'b000, 5'd4, 1'b1, 32'h55, '0, 2'b00);
        flush_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ready: ready=%b, required 0", ready_o);
        end
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready_o !== 1'b0 || busy_o !== 1'b1 || RegWEn_o !== 1'b0 || retired_o !== 32'(exp_ret)) begin
                errors++;
                $display("[TB] FAIL drain_hold: cycle=%0d ready=%b busy=%b RegWEn=%b retired=%0d, required 0/1/0/%0d",
                         i, ready_o, busy_o, RegWEn_o, retired_o, exp_ret);
            end
            if (i == 2) dmem_rvalid_i = 1'b1;
            tick();
        end
        dmem_rvalid_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || RegWEn_o !== 1'b0 || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL drain_done: ready=%b busy=%b RegWEn=%b retired=%0d, required 1/0/0/%0d",
                     ready_o, busy_o, RegWEn_o, retired_o, exp_ret);
        end
        tick();
        valid_i = 1'b0;
        exp_ret++;
        checks++;
        if (RegWEn_o !== 1'b1 || rsW_o !== 5'd4 || dataW_o !== 32'h55 || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL after_drain_write: RegWEn=%b rsW=%0d dataW=%h retired=%0d, required 1/4/00000055/%0d",
                     RegWEn_o, rsW_o, dataW_o, retired_o, exp_ret);
        end
        tick();
    endtask

    task automatic test_rd0();
        set_instr(2'b00, 3'b000, 5'd0, 1'b1, 32'h77, '0, 2'b00);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        exp_ret++;
        checks++;
        if (RegWEn_o !== 1'b0 || rsW_o !== 5'd0 || dataW_o !== 32'h77 || retired_o !== 32'(exp_ret)) begin
            errors++;
            $display("[TB] FAIL rd0_write: RegWEn=%b rsW=%0d dataW=%h retired=%0d, required 0/0/00000077/%0d",
                     RegWEn_o, rsW_o, dataW_o, retired_o, exp_ret);
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        int pulses;
        pulses = 0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_instr(2'b00, 3'b000, 5'(i % 31 + 1), 1'b1, 32'(i * 3), '0, 2'b00);
            tick();
            if (RegWEn_o === 1'b1) pulses++;
        end
        valid_i = 1'b0;
        exp_ret = 17;
        checks++;
        if (pulses != 17 || retired_o !== 32'd17 || retired4 !== 4'd1) begin
            errors++;
            $display("[TB] FAIL counter_wrap: pulses=%0d retired=%0d retired4=%0d, required 17/17/1",
                     pulses, retired_o, retired4);
        end
        tick();
    endtask

    task automatic test_random();
        int          mode;
        logic [31:0] qd[$];
        logic [4:0]  qr[$];
        logic        qe[$];
        logic [4:0]  p_rd;
        logic        p_wen;
        logic [2:0]  p_f3;
        logic [1:0]  p_alo;
        logic [31:0] prev_ret;
        logic        exp_ready, acc;
        logic [31:0] ed;
        logic [4:0]  er;
        logic        ee;
        mode = 0; p_rd = '0; p_wen = 1'b0; p_f3 = '0; p_alo = '0;
        prev_ret = 32'(exp_ret);
        for (int i = 0; i < 410; i++) begin
            if (i < 400) begin
                valid_i       = ($urandom_range(0, 3) != 0);
                flush_i       = ($urandom_range(0, 9) == 0);
                dmem_rvalid_i = ($urandom_range(0, 2) == 0);
            end else begin
                valid_i = 1'b0; flush_i = 1'b0; dmem_rvalid_i = 1'b1;
            end
            dmem_rdata_i = $urandom;
            set_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
            #1;
            exp_ready = (mode == 0) || (mode == 1 && dmem_rvalid_i && !flush_i);
            checks++;
            if (ready_o !== exp_ready) begin
                errors++;
                $display("[TB] FAIL rand_ready: iter=%0d ready=%b, required %b", i, ready_o, exp_ready);
            end
            acc = valid_i && exp_ready && !flush_i;
            if (mode == 1) begin
                if (flush_i) mode = dmem_rvalid_i ? 0 : 2;
                else if (dmem_rvalid_i) begin
                    qd.push_back(fmt_load(dmem_rdata_i, p_alo, p_f3));
                    qr.push_back(p_rd);
                    qe.push_back(p_wen && p_rd != 5'd0);
                    mode = 0;
                end
            end else if (mode == 2 && dmem_rvalid_i) mode = 0;
            if (acc) begin
                if (wbsel_i == 2'b01) begin
                    p_rd = rd_i; p_wen = regwen_i; p_f3 = funct3_i; p_alo = addr_lo_i;
                    mode = 1;
                end else begin
                    qd.push_back(wbsel_i == 2'b10 ? pc4_i : alu_i);
                    qr.push_back(rd_i);
                    qe.push_back(regwen_i && rd_i != 5'd0);
                end
            end
            tick();
            checks++;
            if (retired_o !== prev_ret) begin
                if (qd.size() == 0 || retired_o !== prev_ret + 32'd1) begin
                    errors++;
                    $display("[TB] FAIL rand_unexpected_retire: iter=%0d retired=%0d, required %0d",
                             i, retired_o, prev_ret);
                end else begin
                    ed = qd.pop_front(); er = qr.pop_front(); ee = qe.pop_front();
                    if (dataW_o !== ed || rsW_o !== er || RegWEn_o !== ee) begin
                        errors++;
                        $display("[TB] FAIL rand_write: iter=%0d dataW=%h rsW=%0d RegWEn=%b, required %h/%0d/%b",
                                 i, dataW_o, rsW_o, RegWEn_o, ed, er, ee);
                    end
                end
                prev_ret = retired_o;
            end else if (RegWEn_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_spurious_pulse: iter=%0d RegWEn=%b, required 0", i, RegWEn_o);
            end
        end
        dmem_rvalid_i = 1'b0;
        checks++;
        if (qd.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_drain: outstanding=%0d busy=%b, required 0/0", qd.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_lhu();
        test_flush();
        test_rd0();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
